// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a word handshake, redirects on EX jumps.
// Define ICACHE_EN to build the direct-mapped instruction cache; otherwise every fetch misses.
module if_fetch #(
  parameter int unsigned INDEX_W  = 7,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [5:0]  stall_in,
  input  logic        jump_in,
  input  logic [31:0] jump_target_in,
  input  logic        mem_done_in,
  input  logic [31:0] mem_data_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid_out,
  output logic        stall_req_out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        disc_q;
  logic        disc_d;

  logic        req_d;
  logic [31:0] addr_d;
  logic        sreq_d;
  logic [31:0] pco_d;
  logic [31:0] inst_d;
  logic        vld_d;

  logic        stall_if;
  logic        hit;
  logic [31:0] hit_data;
  logic        fill;

  logic        unused_stall;

  assign stall_if     = stall_in[1];
  assign unused_stall = ^{stall_in[5:2], stall_in[0]};

`ifdef ICACHE_EN
  localparam int unsigned TAG_W = 30 - INDEX_W;
  localparam int unsigned LINES = 1 << INDEX_W;

  logic [INDEX_W-1:0] rd_idx;
  logic [INDEX_W-1:0] wr_idx;
  logic [LINES-1:0]   line_v;
  logic [TAG_W-1:0]   line_tag  [LINES];
  logic [31:0]        line_data [LINES];

  assign rd_idx   = pc_q[INDEX_W+1:2];
  assign wr_idx   = mem_addr_out[INDEX_W+1:2];
  assign hit      = line_v[rd_idx] &&
                    (line_tag[rd_idx] == pc_q[31:INDEX_W+2]);
  assign hit_data = line_data[rd_idx];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_v <= '0;
    end else if (rdy_in && fill) begin
      line_v[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: the valid bits guard them.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      line_tag[wr_idx]  <= mem_addr_out[31:INDEX_W+2];
      line_data[wr_idx] <= mem_data_in;
    end
  end
`else
  logic [INDEX_W-1:0] unused_idx;
  logic               unused_fill;

  assign unused_idx  = pc_q[INDEX_W+1:2];
  assign unused_fill = fill;
  assign hit         = 1'b0;
  assign hit_data    = mem_data_in;
`endif

  // One-hot event decode, priority already folded in.
  logic i_jump;
  logic i_hold;
  logic i_hit;
  logic i_miss;
  logic w_fill_jump;
  logic w_fill_show;
  logic w_fill_drop;
  logic w_redirect;
  logic w_hold;

  assign i_jump = jump_in;
  assign i_hold = !jump_in && stall_if;
  assign i_hit  = !jump_in && !stall_if && hit;
  assign i_miss = !jump_in && !stall_if && !hit;

  assign w_fill_jump = mem_done_in && jump_in;
  assign w_fill_show = mem_done_in && !jump_in &&
                       !stall_if && !disc_q;
  assign w_fill_drop = mem_done_in && !jump_in &&
                       (stall_if || disc_q);
  assign w_redirect  = !mem_done_in && jump_in;
  assign w_hold      = !mem_done_in && !jump_in;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    req_d   = mem_req_out;
    addr_d  = mem_addr_out;
    sreq_d  = stall_req_out;
    pco_d   = pc_out;
    inst_d  = inst_out;
    vld_d   = inst_valid_out;
    fill    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          i_jump: begin
            pc_d  = jump_target_in;
            vld_d = 1'b0;
          end
          i_hold: begin
          end
          i_hit: begin
            pco_d  = pc_q;
            inst_d = hit_data;
            vld_d  = 1'b1;
            pc_d   = pc_q + 32'd4;
          end
          i_miss: begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            sreq_d  = 1'b1;
            vld_d   = 1'b0;
            state_d = S_WAIT;
          end
          default: begin
          end
        endcase
      end

      S_WAIT: begin
        unique case (1'b1)
          w_fill_jump: begin
            fill    = 1'b1;
            req_d   = 1'b0;
            sreq_d  = 1'b0;
            vld_d   = 1'b0;
            pc_d    = jump_target_in;
            disc_d  = 1'b0;
            state_d = S_IDLE;
          end
          w_fill_show: begin
            fill    = 1'b1;
            req_d   = 1'b0;
            sreq_d  = 1'b0;
            pco_d   = mem_addr_out;
            inst_d  = mem_data_in;
            vld_d   = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_IDLE;
          end
          w_fill_drop: begin
            fill    = 1'b1;
            req_d   = 1'b0;
            sreq_d  = 1'b0;
            vld_d   = 1'b0;
            disc_d  = 1'b0;
            state_d = S_IDLE;
          end
          w_redirect: begin
            // Request stays up; the stale word fills the cache only.
            pc_d   = jump_target_in;
            vld_d  = 1'b0;
            disc_d = 1'b1;
          end
          w_hold: begin
          end
          default: begin
          end
        endcase
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      disc_q         <= 1'b0;
      mem_req_out    <= 1'b0;
      mem_addr_out   <= 32'h0;
      stall_req_out  <= 1'b0;
      pc_out         <= 32'h0;
      inst_out       <= 32'h0;
      inst_valid_out <= 1'b0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      disc_q         <= disc_d;
      mem_req_out    <= req_d;
      mem_addr_out   <= addr_d;
      stall_req_out  <= sreq_d;
      pc_out         <= pco_d;
      inst_out       <= inst_d;
      inst_valid_out <= vld_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, corner sequences, random run vs reference model.
// Works with or without ICACHE_EN defined.
module tb_if_fetch;

  localparam int IW = 7;
`ifdef ICACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [5:0]  stall_in = '0;
  logic        jump_in = 1'b0;
  logic [31:0] jump_target_in = '0;
  logic        mem_done_in = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid_out;
  logic        stall_req_out;

  always #5 clk_in = ~clk_in;

  if_fetch #(.INDEX_W(IW), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .stall_in(stall_in),
    .jump_in(jump_in),
    .jump_target_in(jump_target_in),
    .mem_done_in(mem_done_in),
    .mem_data_in(mem_data_in),
    .mem_req_out(mem_req_out),
    .mem_addr_out(mem_addr_out),
    .pc_out(pc_out),
    .inst_out(inst_out),
    .inst_valid_out(inst_valid_out),
    .stall_req_out(stall_req_out)
  );

  int vectors = 0;
  int errors  = 0;

  function automatic logic [31:0] memw(logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A3C_96E1 ^ {a[15:2], a[31:14]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: architectural PC plus a map of cached word addresses.
  logic        m_busy, m_disc, m_req, m_sreq, m_vld;
  logic [31:0] m_pc, m_addr, m_pco, m_inst;
  logic [29:0] m_line [int];

  function automatic int lidx(logic [31:0] a);
    return int'(a[IW+1:2]);
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    return CACHE && m_line.exists(lidx(a)) && m_line[lidx(a)] == a[31:2];
  endfunction

  task automatic model_step();
    if (rst_in) begin
      m_pc = 0; m_busy = 0; m_disc = 0; m_req = 0; m_addr = 0;
      m_sreq = 0; m_pco = 0; m_inst = 0; m_vld = 0;
      m_line.delete();
    end else if (rdy_in) begin
      if (!m_busy) begin
        if (jump_in) begin
          m_pc = jump_target_in; m_vld = 0;
        end else if (!stall_in[1]) begin
          if (m_hit(m_pc)) begin
            m_pco = m_pc; m_inst = memw(m_pc); m_vld = 1; m_pc += 4;
          end else begin
            m_busy = 1; m_req = 1; m_addr = m_pc; m_sreq = 1; m_vld = 0;
          end
        end
      end else if (mem_done_in) begin
        if (CACHE) m_line[lidx(m_addr)] = m_addr[31:2];
        m_busy = 0; m_req = 0; m_sreq = 0; m_vld = 0;
        if (jump_in) m_pc = jump_target_in;
        else if (!stall_in[1] && !m_disc) begin
          m_pco = m_addr; m_inst = memw(m_addr); m_vld = 1; m_pc += 4;
        end
        m_disc = 0;
      end else if (jump_in) begin
        m_pc = jump_target_in; m_vld = 0; m_disc = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("req", mem_req_out, m_req);
    chk("sreq", stall_req_out, m_sreq);
    chk("valid", inst_valid_out, m_vld);
    chk("pc_out", pc_out, m_pco);
    chk("inst", inst_out, m_inst);
    if (m_req) chk("addr", mem_addr_out, m_addr);
  endtask

  // Memory controller: random latency, only completes on a ready cycle.
  bit pend = 0;
  int lat = 0;

  task automatic mem_drive();
    if (rst_in || !mem_req_out) begin
      pend = 0; mem_done_in = 0;
    end else begin
      if (!pend) begin pend = 1; lat = $urandom_range(0, 3); end
      if (lat == 0 && rdy_in) begin
        mem_done_in = 1; pend = 0;
      end else begin
        mem_done_in = 0;
        if (lat != 0) lat--;
      end
    end
    mem_data_in = mem_done_in ? memw(mem_addr_out) : $urandom;
  endtask

  task automatic auto_cycle(bit rst, bit rdy, bit stl, bit jmp,
                            logic [31:0] tgt);
    logic [5:0] s;
    s = 6'($urandom);
    s[1] = stl;
    rst_in = rst; rdy_in = rdy; stall_in = s;
    jump_in = jmp; jump_target_in = tgt;
    mem_drive();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    check_model();
  endtask

  task automatic wait_valid(logic [31:0] pc, int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      auto_cycle(0, 1, 0, 0, 0);
      ok = inst_valid_out && pc_out == pc;
    end
    chk($sformatf("reach pc %h", pc), 32'(ok), 1);
  endtask

  typedef struct {
    bit rst, rdy, stl, jmp;
    logic [31:0] tgt;
    bit done;
    bit e_req;
    logic [31:0] e_addr;
    bit e_sreq, e_vld;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t v(bit rst, bit rdy, bit stl, bit jmp,
                             logic [31:0] tgt, bit done, bit req,
                             logic [31:0] addr, bit sreq, bit vld,
                             logic [31:0] pc);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.stl = stl; r.jmp = jmp; r.tgt = tgt;
    r.done = done; r.e_req = req; r.e_addr = addr; r.e_sreq = sreq;
    r.e_vld = vld; r.e_pc = pc;
    return r;
  endfunction

  task automatic run_table();
    vec_t tbl[$];
    //              rst rdy stl jmp tgt  done req addr sreq vld pc
    tbl.push_back(v(1, 1, 0, 0, 0,      0, 0, 0,      0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 0,      1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 0,      1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 0,      1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      1, 0, 0,      0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 4,      1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 'h100,  0, 1, 4,      1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      1, 0, 0,      0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 'h100,  1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      1, 0, 0,      0, 1, 'h100));
    tbl.push_back(v(0, 1, 1, 0, 0,      0, 0, 0,      0, 1, 'h100));
    tbl.push_back(v(0, 1, 1, 0, 0,      0, 0, 0,      0, 1, 'h100));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 'h104,  1, 0, 'h100));
    tbl.push_back(v(0, 0, 0, 0, 0,      0, 1, 'h104,  1, 0, 'h100));
    tbl.push_back(v(0, 0, 0, 0, 0,      0, 1, 'h104,  1, 0, 'h100));
    tbl.push_back(v(0, 0, 0, 0, 0,      1, 1, 'h104,  1, 0, 'h100));
    tbl.push_back(v(0, 1, 0, 0, 0,      1, 0, 0,      0, 1, 'h104));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 'h108,  1, 0, 'h104));
    tbl.push_back(v(0, 1, 0, 1, 'h200,  1, 0, 0,      0, 0, 'h104));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 'h200,  1, 0, 'h104));
    tbl.push_back(v(0, 1, 0, 0, 0,      1, 0, 0,      0, 1, 'h200));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 'h204,  1, 0, 'h200));
    tbl.push_back(v(1, 1, 0, 0, 0,      0, 0, 0,      0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 'h100,  0, 0, 0,      0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      0, 1, 'h100,  1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0,      1, 0, 0,      0, 1, 'h100));
    foreach (tbl[i]) begin
      rst_in = tbl[i].rst; rdy_in = tbl[i].rdy;
      stall_in = {4'b0, tbl[i].stl, 1'b0};
      jump_in = tbl[i].jmp; jump_target_in = tbl[i].tgt;
      mem_done_in = tbl[i].done;
      mem_data_in = memw(mem_addr_out);
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      chk($sformatf("row%0d req", i), mem_req_out, tbl[i].e_req);
      chk($sformatf("row%0d sreq", i), stall_req_out, tbl[i].e_sreq);
      chk($sformatf("row%0d valid", i), inst_valid_out, tbl[i].e_vld);
      chk($sformatf("row%0d pc_out", i), pc_out, tbl[i].e_pc);
      if (tbl[i].e_req)
        chk($sformatf("row%0d addr", i), mem_addr_out, tbl[i].e_addr);
      if (tbl[i].e_vld)
        chk($sformatf("row%0d inst", i), inst_out, memw(tbl[i].e_pc));
    end
    mem_done_in = 0;
  endtask

  task automatic run_stall_hold();
    auto_cycle(1, 1, 0, 0, 0);
    auto_cycle(0, 1, 0, 1, 32'h20);
    wait_valid(32'h20, 20);
    auto_cycle(0, 1, 0, 1, 32'h20);
    wait_valid(32'h20, 20);
    for (int i = 0; i < 5; i++) begin
      auto_cycle(0, 1, 1, 0, 0);
      chk("hold pc", pc_out, 32'h20);
      chk("hold inst", inst_out, memw(32'h20));
      chk("hold valid", inst_valid_out, 1);
      chk("hold noreq", mem_req_out, 0);
    end
    wait_valid(32'h24, 20);
  endtask

  task automatic run_loop();
    auto_cycle(1, 1, 0, 0, 0);
    wait_valid(32'hC, 40);
    auto_cycle(0, 1, 0, 1, 32'h0);
`ifdef ICACHE_EN
    for (int k = 0; k < 4; k++) begin
      auto_cycle(0, 1, 0, 0, 0);
      chk("loop2 valid", inst_valid_out, 1);
      chk("loop2 pc", pc_out, 32'(4 * k));
      chk("loop2 noreq", mem_req_out, 0);
    end
`else
    begin
      int vcnt = 0;
      int reqs = 0;
      bit pv = 0;
      bit pr = 0;
      for (int i = 0; i < 40 && vcnt < 4; i++) begin
        auto_cycle(0, 1, 0, 0, 0);
        if (mem_req_out && !pr) reqs++;
        chk("loop2 spacing", 32'(inst_valid_out && pv), 0);
        if (inst_valid_out) begin
          chk("loop2 pc", pc_out, 32'(4 * vcnt));
          vcnt++;
        end
        pv = inst_valid_out;
        pr = mem_req_out;
      end
      chk("loop2 count", 32'(vcnt), 4);
      chk("loop2 reqs", 32'(reqs), 4);
    end
`endif
  endtask

  task automatic run_random(int n);
    auto_cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      bit r, rd, st, jp;
      logic [31:0] tgt;
      int sel;
      r  = ($urandom_range(0, 299) == 0);
      rd = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 4) == 0);
      jp = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       tgt = 32'($urandom_range(0, 63)) << 2;
      else if (sel < 9)  tgt = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      else               tgt = 32'hFFFF_FFF8;
      auto_cycle(r, rd, st, jp, tgt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    run_table();
    run_stall_hold();
    run_loop();
    run_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
